// File: rtl/decode_stage_hz.sv
// Decode stage + ID/EX register: register file with WB write-through bypass,
// load-use bubble insertion, downstream stall hold and a saturating bubble counter.
module decode_stage_hz #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int CTRL_W   = 9,
   parameter int LOAD_BIT = 1,
   parameter int BCNT_W   = 16,
   localparam int AW      = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       InstrD,
   input  logic              ValidD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic [XLEN-1:0]   ImmExtD,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic              RegWriteW,
   input  logic [AW-1:0]     RD_W,
   input  logic [XLEN-1:0]   ResultW,
   input  logic              FlushE,
   input  logic              StallE,
   output logic [CTRL_W-1:0] CtrlE,
   output logic              ValidE,
   output logic [XLEN-1:0]   RD1_E,
   output logic [XLEN-1:0]   RD2_E,
   output logic [XLEN-1:0]   Imm_Ext_E,
   output logic [AW-1:0]     RD_E,
   output logic [AW-1:0]     RS1_E,
   output logic [AW-1:0]     RS2_E,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic              StallF,
   output logic              StallD,
   output logic [BCNT_W-1:0] BubbleCnt
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              valid;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [AW-1:0]     rd;
      logic [AW-1:0]     rs1;
      logic [AW-1:0]     rs2;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc4;
   } ex_t;

   logic [XLEN-1:0]         rf_q [NREG];
   logic [1:0][AW-1:0]      rs;
   logic [1:0][XLEN-1:0]    rdata;
   logic [AW-1:0]           rd_d;
   logic                    wb_en;
   logic                    lwstall;
   ex_t                     e_q, e_d;
   logic [BCNT_W-1:0]       bcnt_q, bcnt_d;

   assign rs[0] = AW'(InstrD[19:15]);
   assign rs[1] = AW'(InstrD[24:20]);
   assign rd_d  = AW'(InstrD[11:7]);
   assign wb_en = RegWriteW && (RD_W != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_en) begin
         rf_q[RD_W] <= ResultW;
      end
   end

   // x0 is forced to zero ahead of the bypass so a stray WB to x0 never leaks
   genvar p;
   for (p = 0; p < 2; p++) begin : g_rd
      assign rdata[p] = (rs[p] == '0)                 ? '0      :
                        (wb_en && (RD_W == rs[p]))    ? ResultW :
                                                        rf_q[rs[p]];
   end

   // Both source fields are treated as used regardless of instruction format
   assign lwstall = ValidD && e_q.valid && e_q.ctrl[LOAD_BIT] && (e_q.rd != '0) &&
                    ((rs[0] == e_q.rd) || (rs[1] == e_q.rd));

   assign StallD = lwstall || StallE;
   assign StallF = StallD;

   always_comb begin
      e_d    = e_q;
      bcnt_d = bcnt_q;
      if (FlushE) begin
         e_d = '0;
      end else if (StallE) begin
         e_d = e_q;
      end else if (lwstall) begin
         e_d = '0;
         if (bcnt_q != '1) bcnt_d = bcnt_q + BCNT_W'(1);
      end else begin
         e_d.ctrl  = ValidD ? CtrlD : '0;
         e_d.valid = ValidD;
         e_d.rd1   = rdata[0];
         e_d.rd2   = rdata[1];
         e_d.imm   = ImmExtD;
         e_d.rd    = rd_d;
         e_d.rs1   = rs[0];
         e_d.rs2   = rs[1];
         e_d.pc    = PCD;
         e_d.pc4   = PCPlus4D;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_q    <= '0;
         bcnt_q <= '0;
      end else begin
         e_q    <= e_d;
         bcnt_q <= bcnt_d;
      end
   end

   assign CtrlE     = e_q.ctrl;
   assign ValidE    = e_q.valid;
   assign RD1_E     = e_q.rd1;
   assign RD2_E     = e_q.rd2;
   assign Imm_Ext_E = e_q.imm;
   assign RD_E      = e_q.rd;
   assign RS1_E     = e_q.rs1;
   assign RS2_E     = e_q.rs2;
   assign PCE       = e_q.pc;
   assign PCPlus4E  = e_q.pc4;
   assign BubbleCnt = bcnt_q;

endmodule
